// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the I/D main-memory arbiter.
//             Requester IDs, the 1-bit requester-ID type, arbiter state
//             encoding and a small helper returning the opposite requester.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  // Requester identifiers: the instruction cache is 0, the data cache is 1.
  typedef logic req_id_t;

  localparam req_id_t REQ_I = 1'b0;
  localparam req_id_t REQ_D = 1'b1;

  // ARB    : requests are arbitrated and may fire.
  // WDATA  : a write request has fired; its single data beat is still owed.
  typedef enum logic [0:0] {
    ARB   = 1'b0,
    WDATA = 1'b1
  } arb_state_t;

  // The requester that is not 'id' (two-requester round robin).
  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_id_fifo
//  Purpose  : In-order tracking FIFO of requester IDs for outstanding reads.
//             One 1-bit entry per read issued to memory; the head tells the
//             arbiter which cache the next read response belongs to.
//  Ports    : clk, reset_n (async, active low)
//             push/din   - enqueue a requester ID
//             pop        - dequeue the head (response arrived)
//             dout       - current head entry
//             full/empty - occupancy flags
//             underflow  - pop requested while empty (entry is not consumed)
//  Notes    : DEPTH must be a power of two (>= 2) so pointers wrap naturally.
//             A push at full is accepted when a pop happens in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  logic    pop,
  input  req_id_t din,
  output req_id_t dout,
  output logic    full,
  output logic    empty,
  output logic    underflow
);

  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(DEPTH);

  logic [DEPTH-1:0]    storage_q, storage_d;
  logic [PTR_BITS-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CNT_BITS-1:0] count_q,   count_d;
  logic                do_push, do_pop;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == DEPTH_CNT);
    dout      = storage_q[rd_ptr_q];
    underflow = pop && empty;

    do_pop    = pop && !empty;
    // At full the slot being freed by the pop is reused by the push.
    do_push   = push && (!full || pop);

    storage_d = storage_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (do_push) begin
      storage_d[wr_ptr_q] = din;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      storage_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      storage_q <= storage_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule : mem_arb_id_fifo
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one main-memory port between the instruction cache (I,
//             requester 0) and the data cache (D, requester 1). Round-robin
//             request arbitration, routing of the one-beat write-data channel
//             to the owning cache, and in-order read-response routing through
//             an ID FIFO. The request path is a combinational pass-through.
//  Ports    : clk, reset_n (async, active low)
//             i_* / d_*  - per-cache request, write-data and response channels
//             mem_*      - downstream memory port (opposite direction)
//             err_unexpected_resp - sticky, response with no read outstanding
//  Options  : `define MEM_ARBITER_PERF_EN adds perf_i_grants, perf_d_grants and
//             perf_conflict_cycles (32-bit saturating counters).
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_BITS       = 28,
  parameter int MEM_DATA_BITS   = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,

  // Instruction cache
  input  logic                       i_mem_req_val,
  output logic                       i_mem_req_rdy,
  input  logic [ADDR_BITS-1:0]       i_mem_req_addr,
  input  logic                       i_mem_req_rw,
  input  logic                       i_mem_req_data_valid,
  output logic                       i_mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   i_mem_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] i_mem_req_data_mask,
  output logic                       i_mem_resp_val,
  output logic [MEM_DATA_BITS-1:0]   i_mem_resp_data,

  // Data cache
  input  logic                       d_mem_req_val,
  output logic                       d_mem_req_rdy,
  input  logic [ADDR_BITS-1:0]       d_mem_req_addr,
  input  logic                       d_mem_req_rw,
  input  logic                       d_mem_req_data_valid,
  output logic                       d_mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   d_mem_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] d_mem_req_data_mask,
  output logic                       d_mem_resp_val,
  output logic [MEM_DATA_BITS-1:0]   d_mem_resp_data,

  // Memory side
  output logic                       mem_req_val,
  input  logic                       mem_req_rdy,
  output logic [ADDR_BITS-1:0]       mem_req_addr,
  output logic                       mem_req_rw,
  output logic                       mem_req_data_valid,
  input  logic                       mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                       mem_resp_val,
  input  logic [MEM_DATA_BITS-1:0]   mem_resp_data,

  output logic                       err_unexpected_resp
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0]                perf_i_grants,
  output logic [31:0]                perf_d_grants,
  output logic [31:0]                perf_conflict_cycles
`endif
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_t state_q,      state_d;
  req_id_t    last_grant_q, last_grant_d;
  req_id_t    owner_q,      owner_d;
  logic       err_q,        err_d;

  // --------------------------------------------------------------------------
  // Read ID FIFO
  // --------------------------------------------------------------------------
  logic    fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_underflow;
  req_id_t fifo_din, fifo_head;

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .din       (fifo_din),
    .dout      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .underflow (fifo_underflow)
  );

  // --------------------------------------------------------------------------
  // Arbitration and channel routing
  // --------------------------------------------------------------------------
  logic    both_val, any_val, in_arb;
  logic    pref_rw, other_rw, read_blocked, read_stall;
  req_id_t pref_id, grant_id, data_src;
  logic    grant_rw, grant_rdy, req_fire, data_route, data_fire;

  always_comb begin
    both_val = i_mem_req_val && d_mem_req_val;
    any_val  = i_mem_req_val || d_mem_req_val;
    in_arb   = reset_n && (state_q == ARB);

    if (both_val)           pref_id = other_req(last_grant_q);
    else if (d_mem_req_val) pref_id = REQ_D;
    else                    pref_id = REQ_I;

    pref_rw  = (pref_id == REQ_D) ? d_mem_req_rw : i_mem_req_rw;
    other_rw = (pref_id == REQ_D) ? i_mem_req_rw : d_mem_req_rw;

    // A full FIFO blocks reads, unless a response pops an entry this cycle
    // and frees the slot for the new read's ID.
    read_blocked = fifo_full && !mem_resp_val;

    // A blocked read yields the port only to a competing write.
    if (both_val && !pref_rw && read_blocked && other_rw) grant_id = other_req(pref_id);
    else                                                  grant_id = pref_id;

    grant_rw   = (grant_id == REQ_D) ? d_mem_req_rw : i_mem_req_rw;
    read_stall = !grant_rw && read_blocked;

    mem_req_val   = in_arb && any_val && !read_stall;
    mem_req_addr  = (grant_id == REQ_D) ? d_mem_req_addr : i_mem_req_addr;
    mem_req_rw    = grant_rw;
    grant_rdy     = in_arb && any_val && mem_req_rdy && !read_stall;
    i_mem_req_rdy = grant_rdy && (grant_id == REQ_I);
    d_mem_req_rdy = grant_rdy && (grant_id == REQ_D);
    req_fire      = mem_req_val && mem_req_rdy;

    // Write data is routed only to the owner in WDATA, or in ARB to the
    // requester whose write request is firing this very cycle.
    data_route = 1'b0;
    data_src   = grant_id;
    if (reset_n && (state_q == WDATA)) begin
      data_route = 1'b1;
      data_src   = owner_q;
    end else if (req_fire && grant_rw) begin
      data_route = 1'b1;
      data_src   = grant_id;
    end

    mem_req_data_valid   = data_route &&
                           ((data_src == REQ_D) ? d_mem_req_data_valid : i_mem_req_data_valid);
    mem_req_data_bits    = (data_src == REQ_D) ? d_mem_req_data_bits : i_mem_req_data_bits;
    mem_req_data_mask    = (data_src == REQ_D) ? d_mem_req_data_mask : i_mem_req_data_mask;
    i_mem_req_data_ready = data_route && (data_src == REQ_I) && mem_req_data_ready;
    d_mem_req_data_ready = data_route && (data_src == REQ_D) && mem_req_data_ready;
    data_fire            = mem_req_data_valid && mem_req_data_ready;

    // Reads enqueue their requester; responses dequeue the head.
    fifo_push = req_fire && !grant_rw;
    fifo_din  = grant_id;
    fifo_pop  = reset_n && mem_resp_val;

    i_mem_resp_val  = fifo_pop && !fifo_empty && (fifo_head == REQ_I);
    d_mem_resp_val  = fifo_pop && !fifo_empty && (fifo_head == REQ_D);
    i_mem_resp_data = mem_resp_data;
    d_mem_resp_data = mem_resp_data;

    // Next state
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    err_d        = err_q || fifo_underflow;

    case (state_q)
      ARB: begin
        if (req_fire) begin
          last_grant_d = grant_id;
          if (grant_rw) begin
            owner_d = grant_id;
            if (!data_fire) state_d = WDATA;
          end
        end
      end
      WDATA: begin
        if (data_fire) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB;
      last_grant_q <= REQ_D;
      owner_q      <= REQ_I;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      err_q        <= err_d;
    end
  end

  assign err_unexpected_resp = err_q;

`ifdef MEM_ARBITER_PERF_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [31:0] perf_i_q, perf_i_d;
  logic [31:0] perf_d_q, perf_d_d;
  logic [31:0] perf_c_q, perf_c_d;

  always_comb begin
    perf_i_d = perf_i_q;
    perf_d_d = perf_d_q;
    perf_c_d = perf_c_q;
    if (req_fire && (grant_id == REQ_I) && (perf_i_q != '1)) perf_i_d = perf_i_q + 1'b1;
    if (req_fire && (grant_id == REQ_D) && (perf_d_q != '1)) perf_d_d = perf_d_q + 1'b1;
    if (both_val && (perf_c_q != '1))                        perf_c_d = perf_c_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
      perf_c_q <= '0;
    end else begin
      perf_i_q <= perf_i_d;
      perf_d_q <= perf_d_d;
      perf_c_q <= perf_c_d;
    end
  end

  assign perf_i_grants        = perf_i_q;
  assign perf_d_grants        = perf_d_q;
  assign perf_conflict_cycles = perf_c_q;
`endif

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter (default params).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_mem_req_val, i_mem_req_rdy, i_mem_req_rw;
  logic [AW-1:0] i_mem_req_addr;
  logic          i_mem_req_data_valid, i_mem_req_data_ready;
  logic [DW-1:0] i_mem_req_data_bits;
  logic [MW-1:0] i_mem_req_data_mask;
  logic          i_mem_resp_val;
  logic [DW-1:0] i_mem_resp_data;
  logic          d_mem_req_val, d_mem_req_rdy, d_mem_req_rw;
  logic [AW-1:0] d_mem_req_addr;
  logic          d_mem_req_data_valid, d_mem_req_data_ready;
  logic [DW-1:0] d_mem_req_data_bits;
  logic [MW-1:0] d_mem_req_data_mask;
  logic          d_mem_resp_val;
  logic [DW-1:0] d_mem_resp_data;
  logic          mem_req_val, mem_req_rdy, mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [DW-1:0] mem_req_data_bits;
  logic [MW-1:0] mem_req_data_mask;
  logic          mem_resp_val;
  logic [DW-1:0] mem_resp_data;
  logic          err_unexpected_resp;
`ifdef MEM_ARBITER_PERF_EN
  logic [31:0]   perf_i_grants, perf_d_grants, perf_conflict_cycles;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [AW-1:0] I_ADDR = 28'h0000111;
  localparam logic [AW-1:0] D_ADDR = 28'h0000040;
  localparam logic [AW-1:0] W_ADDR = 28'h0000100;
  localparam logic [DW-1:0] RDATA  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
  localparam logic [DW-1:0] D_WDAT = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [DW-1:0] I_WDAT = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_BITS       (AW),
    .MEM_DATA_BITS   (DW),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .i_mem_req_val        (i_mem_req_val),
    .i_mem_req_rdy        (i_mem_req_rdy),
    .i_mem_req_addr       (i_mem_req_addr),
    .i_mem_req_rw         (i_mem_req_rw),
    .i_mem_req_data_valid (i_mem_req_data_valid),
    .i_mem_req_data_ready (i_mem_req_data_ready),
    .i_mem_req_data_bits  (i_mem_req_data_bits),
    .i_mem_req_data_mask  (i_mem_req_data_mask),
    .i_mem_resp_val       (i_mem_resp_val),
    .i_mem_resp_data      (i_mem_resp_data),
    .d_mem_req_val        (d_mem_req_val),
    .d_mem_req_rdy        (d_mem_req_rdy),
    .d_mem_req_addr       (d_mem_req_addr),
    .d_mem_req_rw         (d_mem_req_rw),
    .d_mem_req_data_valid (d_mem_req_data_valid),
    .d_mem_req_data_ready (d_mem_req_data_ready),
    .d_mem_req_data_bits  (d_mem_req_data_bits),
    .d_mem_req_data_mask  (d_mem_req_data_mask),
    .d_mem_resp_val       (d_mem_resp_val),
    .d_mem_resp_data      (d_mem_resp_data),
    .mem_req_val          (mem_req_val),
    .mem_req_rdy          (mem_req_rdy),
    .mem_req_addr         (mem_req_addr),
    .mem_req_rw           (mem_req_rw),
    .mem_req_data_valid   (mem_req_data_valid),
    .mem_req_data_ready   (mem_req_data_ready),
    .mem_req_data_bits    (mem_req_data_bits),
    .mem_req_data_mask    (mem_req_data_mask),
    .mem_resp_val         (mem_resp_val),
    .mem_resp_data        (mem_resp_data),
    .err_unexpected_resp  (err_unexpected_resp)
`ifdef MEM_ARBITER_PERF_EN
    ,
    .perf_i_grants        (perf_i_grants),
    .perf_d_grants        (perf_d_grants),
    .perf_conflict_cycles (perf_conflict_cycles)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling (mid-cycle).
  task automatic settle();
    #3;
  endtask

  task automatic idle();
    i_mem_req_val = 1'b0; i_mem_req_rw = 1'b0; i_mem_req_addr = I_ADDR;
    i_mem_req_data_valid = 1'b0; i_mem_req_data_bits = I_WDAT; i_mem_req_data_mask = '1;
    d_mem_req_val = 1'b0; d_mem_req_rw = 1'b0; d_mem_req_addr = D_ADDR;
    d_mem_req_data_valid = 1'b0; d_mem_req_data_bits = D_WDAT; d_mem_req_data_mask = 16'h00FF;
    mem_req_rdy = 1'b1; mem_req_data_ready = 1'b1;
    mem_resp_val = 1'b0; mem_resp_data = RDATA;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset_n = 1'b0;

    // ---- During reset: all handshake outputs forced low ----
    i_mem_req_val = 1'b1; mem_resp_val = 1'b1;
    settle();
    chk1("rst_mem_req_val", mem_req_val, 1'b0);
    chk1("rst_i_rdy",       i_mem_req_rdy, 1'b0);
    chk1("rst_i_resp_val",  i_mem_resp_val, 1'b0);
    chk1("rst_err",         err_unexpected_resp, 1'b0);
    step();
    reset_n = 1'b1;
    idle();

    // ---- Single D read, then its response ----
    d_mem_req_val = 1'b1;
    settle();
    chk1("t1_d_rdy",   d_mem_req_rdy, 1'b1);
    chk1("t1_i_rdy",   i_mem_req_rdy, 1'b0);
    chk1("t1_val",     mem_req_val, 1'b1);
    chkw("t1_addr",    DW'(mem_req_addr), DW'(D_ADDR));
    chk1("t1_rw",      mem_req_rw, 1'b0);
    step();
    idle();
    mem_resp_val = 1'b1;
    settle();
    chk1("t1_d_resp",  d_mem_resp_val, 1'b1);
    chk1("t1_i_resp",  i_mem_resp_val, 1'b0);
    chkw("t1_i_rdata", i_mem_resp_data, RDATA);
    chkw("t1_d_rdata", d_mem_resp_data, RDATA);
    step();
    idle();

    // ---- Both reading every cycle: I,D,I,D ----
    i_mem_req_val = 1'b1; d_mem_req_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk1("t2_i_rdy", i_mem_req_rdy, (k % 2) == 0);
      chk1("t2_d_rdy", d_mem_req_rdy, (k % 2) == 1);
      chkw("t2_addr",  DW'(mem_req_addr), DW'(((k % 2) == 0) ? I_ADDR : D_ADDR));
      step();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      mem_resp_val = 1'b1;
      settle();
      chk1("t2_i_resp", i_mem_resp_val, (k % 2) == 0);
      chk1("t2_d_resp", d_mem_resp_val, (k % 2) == 1);
      step();
    end
    idle();

    // ---- D write with data 3 cycles late; I read waits ----
    d_mem_req_val = 1'b1; d_mem_req_rw = 1'b1; d_mem_req_addr = W_ADDR;
    settle();
    chk1("t3_d_rdy",   d_mem_req_rdy, 1'b1);
    chk1("t3_rw",      mem_req_rw, 1'b1);
    chk1("t3_dvalid0", mem_req_data_valid, 1'b0);
    step();
    d_mem_req_val = 1'b0;
    i_mem_req_val = 1'b1; i_mem_req_data_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk1("t3_wait_i_rdy",   i_mem_req_rdy, 1'b0);
      chk1("t3_wait_val",     mem_req_val, 1'b0);
      chk1("t3_wait_i_dready", i_mem_req_data_ready, 1'b0);
      chk1("t3_wait_d_dready", d_mem_req_data_ready, 1'b1);
      chk1("t3_wait_dvalid",  mem_req_data_valid, 1'b0);
      step();
    end
    d_mem_req_data_valid = 1'b1;
    settle();
    chk1("t3_beat_valid",  mem_req_data_valid, 1'b1);
    chkw("t3_beat_bits",   mem_req_data_bits, D_WDAT);
    chkw("t3_beat_mask",   DW'(mem_req_data_mask), DW'(16'h00FF));
    chk1("t3_beat_i_rdy",  i_mem_req_rdy, 1'b0);
    step();
    d_mem_req_data_valid = 1'b0;
    settle();
    chk1("t3_after_i_rdy", i_mem_req_rdy, 1'b1);
    chk1("t3_after_rw",    mem_req_rw, 1'b0);
    step();
    idle();
    mem_resp_val = 1'b1;
    settle();
    chk1("t3_i_resp", i_mem_resp_val, 1'b1);
    step();
    idle();

    // ---- FIFO full: 4 I reads, 5th held, D writes meanwhile ----
    i_mem_req_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk1("t4_fill_i_rdy", i_mem_req_rdy, 1'b1);
      step();
    end
    settle();
    chk1("t4_full_val",   mem_req_val, 1'b0);
    chk1("t4_full_i_rdy", i_mem_req_rdy, 1'b0);
    step();
    d_mem_req_val = 1'b1; d_mem_req_rw = 1'b1; d_mem_req_addr = W_ADDR;
    d_mem_req_data_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk1("t4_w_d_rdy",    d_mem_req_rdy, 1'b1);
      chk1("t4_w_i_rdy",    i_mem_req_rdy, 1'b0);
      chk1("t4_w_rw",       mem_req_rw, 1'b1);
      chk1("t4_w_dready",   d_mem_req_data_ready, 1'b1);
      chk1("t4_w_dvalid",   mem_req_data_valid, 1'b1);
      step();
    end
    d_mem_req_val = 1'b0; d_mem_req_data_valid = 1'b0; d_mem_req_rw = 1'b0;
    mem_resp_val = 1'b1;
    settle();
    chk1("t4_swap_i_rdy",  i_mem_req_rdy, 1'b1);
    chk1("t4_swap_val",    mem_req_val, 1'b1);
    chk1("t4_swap_i_resp", i_mem_resp_val, 1'b1);
    step();
    mem_resp_val = 1'b0;
    settle();
    chk1("t4_still_full", mem_req_val, 1'b0);
    step();
    idle();
    for (int k = 0; k < 4; k++) begin
      mem_resp_val = 1'b1;
      settle();
      chk1("t4_drain_i_resp", i_mem_resp_val, 1'b1);
      step();
    end

    // ---- Unexpected response ----
    settle();
    chk1("t5_unexp_i_resp", i_mem_resp_val, 1'b0);
    chk1("t5_unexp_d_resp", d_mem_resp_val, 1'b0);
    step();
    idle();
    settle();
    chk1("t5_err_set", err_unexpected_resp, 1'b1);
    step();
    settle();
    chk1("t5_err_sticky", err_unexpected_resp, 1'b1);
    step();

    // ---- Async reset in WDATA ----
    d_mem_req_val = 1'b1; d_mem_req_rw = 1'b1; d_mem_req_addr = W_ADDR;
    settle();
    chk1("t6_w_d_rdy", d_mem_req_rdy, 1'b1);
    step();
    idle();
    i_mem_req_val = 1'b1;
    settle();
    chk1("t6_wdata_d_dready", d_mem_req_data_ready, 1'b1);
    chk1("t6_wdata_i_rdy",    i_mem_req_rdy, 1'b0);
    #1;
    reset_n = 1'b0;
    d_mem_req_data_valid = 1'b1;
    #1;
    chk1("t6_rst_err",       err_unexpected_resp, 1'b0);
    chk1("t6_rst_d_dready",  d_mem_req_data_ready, 1'b0);
    chk1("t6_rst_dvalid",    mem_req_data_valid, 1'b0);
    chk1("t6_rst_val",       mem_req_val, 1'b0);
    step();
    reset_n = 1'b1;
    idle();
    i_mem_req_val = 1'b1; d_mem_req_val = 1'b1;
    settle();
    chk1("t6_post_i_rdy", i_mem_req_rdy, 1'b1);
    chk1("t6_post_d_rdy", d_mem_req_rdy, 1'b0);
    step();
    idle();

`ifdef MEM_ARBITER_PERF_EN
    // ---- Performance counters ----
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    settle();
    chkw("p_rst_conf", DW'(perf_conflict_cycles), DW'(0));
    chkw("p_rst_i",    DW'(perf_i_grants), DW'(0));
    step();
    mem_req_rdy = 1'b0;
    i_mem_req_val = 1'b1; d_mem_req_val = 1'b1;
    for (int k = 0; k < 10; k++) step();
    idle();
    settle();
    chkw("p_conf10", DW'(perf_conflict_cycles), DW'(10));
    chkw("p_i0",     DW'(perf_i_grants), DW'(0));
    step();
    i_mem_req_val = 1'b1;
    step();
    idle();
    settle();
    chkw("p_i1", DW'(perf_i_grants), DW'(1));
    chkw("p_d0", DW'(perf_d_grants), DW'(0));
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (requester 0, I) and the data cache (requester 1, D).
- Arbitrates request issue, routes the one-beat write-data channel to the owning cache, and routes in-order read responses back using an ID FIFO.
- Sits between both cache instances and the memory model/DRAM controller.

Parameters:
- ADDR_BITS, 28, memory line-address width (128-bit granule).
- MEM_DATA_BITS, 128, memory data width; mask width is MEM_DATA_BITS/8.
- MAX_OUTSTANDING, 4, read ID FIFO depth; power of two, minimum 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- {i,d}_mem_req_val  in  1  cache request valid
- {i,d}_mem_req_rdy  out  1  request accepted this cycle
- {i,d}_mem_req_addr  in  ADDR_BITS  line address
- {i,d}_mem_req_rw  in  1  1 = write
- {i,d}_mem_req_data_valid  in  1  write beat valid
- {i,d}_mem_req_data_ready  out  1  write beat accepted
- {i,d}_mem_req_data_bits  in  MEM_DATA_BITS  write data
- {i,d}_mem_req_data_mask  in  MEM_DATA_BITS/8  byte mask
- {i,d}_mem_resp_val  out  1  read data valid to that cache
- {i,d}_mem_resp_data  out  MEM_DATA_BITS  read data (shared fanout of mem_resp_data)
- mem_req_val/rdy, mem_req_addr, mem_req_rw, mem_req_data_valid/ready/bits/mask, mem_resp_val, mem_resp_data: downstream copies of the above, opposite direction
- err_unexpected_resp  out  1  sticky: mem_resp_val arrived with the ID FIFO empty

Behaviour:
- Reset (reset_n low, async):
  - State ARB, last_grant = D (so I wins the first tie), FIFO empty, err cleared.
  - All rdy, val and resp_val outputs 0 while reset_n is low.
- States:
  - ARB: arbitrate requests.
  - WDATA: a write request has fired, its data beat is pending; owner register holds the requester ID.
- ARB arbitration:
  - Combinational grant from valids only; a val never depends on a rdy.
  - One valid: that requester is granted.
  - Both valid: round-robin; grant the requester that is not last_grant.
  - Downstream mem_req_val/addr/rw are muxed from the granted requester.
  - Granted x_mem_req_rdy = mem_req_rdy && (rw || FIFO not full). Ungranted rdy = 0.
  - A read with the FIFO full holds mem_req_val low. The other requester may be granted instead only if it is issuing a write.
- On request fire:
  - last_grant updates.
  - Read: push the requester ID into the FIFO.
  - Write: owner <- ID.
    - If the owner's data beat also fires in the same cycle, stay in ARB.
    - Otherwise go to WDATA.
- WDATA:
  - No requests are granted.
  - Data channel connects owner <-> memory only: mem_req_data_valid = owner's data_valid, owner's data_ready = mem_req_data_ready, non-owner data_ready = 0.
  - On data fire, return to ARB.
- Data channel in ARB: the same-cycle beat is routed only for the requester whose write request is firing. All other data_ready = 0.
- Responses:
  - mem_resp_val pops the FIFO head and asserts resp_val for that requester only, same cycle (0-cycle latency, combinational).
  - resp_data is driven to both caches unconditionally.
- FIFO full:
  - Push and pop in the same cycle are both performed; count unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Empty pop (mem_resp_val with the FIFO empty): no resp_val is asserted, err_unexpected_resp sets and holds until reset.
- Reset mid-operation: all tracking is discarded. Responses arriving after reset for pre-reset reads set err. The system must quiesce memory before asserting reset.
- Request-path latency is 0 cycles (combinational pass-through). No buffering of addresses or data.

Optional Feature:
- Macro: MEM_ARBITER_PERF_EN.
- Defined:
  - Adds 32-bit outputs perf_i_grants, perf_d_grants and perf_conflict_cycles.
  - perf_conflict_cycles counts cycles where both requester vals are high, in ARB or WDATA.
  - All three clear on reset and saturate at 2^32-1.
- Undefined: the ports and counters do not exist. Functional behaviour is identical either way.

Decomposition:
- Shared package mem_arb_pkg:
  - Requester ID constants REQ_I=0, REQ_D=1 and the 1-bit requester-ID type.
  - State encoding ARB=0, WDATA=1.
- Sub-module mem_arb_id_fifo:
  - Parameterised depth, 1-bit entries.
  - Ports: push, pop, din, dout, full, empty.
  - Handles simultaneous push/pop at full and at empty. Push while empty with no pop is normal. Pop while empty reports underflow to the parent.

Test Plan:
- Only D issues read 0x0000040, mem_req_rdy=1 -> d_mem_req_rdy=1 same cycle, FIFO count 1. Memory returns 0xDEAD... -> d_mem_resp_val=1, i_mem_resp_val=0.
- I and D both valid every cycle for 4 read fires -> grant order I,D,I,D. Responses routed in that order.
- D write 0x100 with data beat delayed 3 cycles, I read valid throughout -> I rdy=0 for those 3 cycles and i_data_ready=0. D data fires, then I is granted the next cycle.
- 4 I reads outstanding (FIFO full), 5th I read held (mem_req_val=0). D write granted meanwhile. mem_resp_val plus a new I read in the same cycle -> pop and push both occur, count stays 4.
- mem_resp_val pulse with no outstanding reads -> no resp_val, err_unexpected_resp=1 sticky. Async reset_n low mid-WDATA -> all outputs 0 immediately, state ARB, err=0.
- With MEM_ARBITER_PERF_EN: 10 cycles both valid -> perf_conflict_cycles=10. Grants match fire counts.
